// File: rtl/interrupt_request_capture.sv
// Interrupt capture front end: per-channel synchroniser, edge/level detect,
// sticky pending and overflow flags with software set/clear, and an event pulse.
module interrupt_request_capture #(
  parameter int N_INTERRUPTS = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [N_INTERRUPTS-1:0]   irq_in,
  input  logic [2*N_INTERRUPTS-1:0] mode,
  input  logic [N_INTERRUPTS-1:0]   enable,
  input  logic [N_INTERRUPTS-1:0]   sw_set,
  input  logic [N_INTERRUPTS-1:0]   sw_clear,
  output logic [N_INTERRUPTS-1:0]   pending,
  output logic [N_INTERRUPTS-1:0]   overflow,
  output logic [N_INTERRUPTS-1:0]   irq_pulse,
  output logic                      irq_any
);

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_LEVEL = 2'b11;

  logic [N_INTERRUPTS-1:0] s_s;
  logic [N_INTERRUPTS-1:0] p_r;
  logic [N_INTERRUPTS-1:0] raw_s;
  logic [N_INTERRUPTS-1:0] edge_mode_s;
  logic [N_INTERRUPTS-1:0] evt_s;
  logic [N_INTERRUPTS-1:0] ovf_set_s;
  logic [N_INTERRUPTS-1:0] pending_r;
  logic [N_INTERRUPTS-1:0] overflow_r;
  logic [N_INTERRUPTS-1:0] irq_pulse_r;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_s = irq_in;
    end else begin : g_sync
      logic [N_INTERRUPTS-1:0] sync_r [SYNC_STAGES];

      // Synchroniser chain; reset discards any in-flight samples.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_r[k] <= '0;
          end
        end else begin
          sync_r[0] <= irq_in;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_r[k] <= sync_r[k-1];
          end
        end
      end

      assign s_s = sync_r[SYNC_STAGES-1];
    end
  endgenerate

  // Per-channel raw event decode; p_r is shared across modes so a mode switch never fakes an edge.
  always_comb begin
    raw_s       = '0;
    edge_mode_s = '0;
    for (int i = 0; i < N_INTERRUPTS; i++) begin
      case (mode[2*i +: 2])
        MODE_RISE: begin
          raw_s[i]       = s_s[i] & ~p_r[i];
          edge_mode_s[i] = 1'b1;
        end
        MODE_FALL: begin
          raw_s[i]       = ~s_s[i] & p_r[i];
          edge_mode_s[i] = 1'b1;
        end
        MODE_BOTH: begin
          raw_s[i]       = s_s[i] ^ p_r[i];
          edge_mode_s[i] = 1'b1;
        end
        MODE_LEVEL: begin
          raw_s[i]       = s_s[i];
          edge_mode_s[i] = 1'b0;
        end
        default: begin
          raw_s[i]       = 1'b0;
          edge_mode_s[i] = 1'b0;
        end
      endcase
    end
  end

  assign evt_s     = raw_s & enable;
  // Level mode re-asserts every cycle, so only edge modes can report a lost event.
  assign ovf_set_s = evt_s & pending_r & ~sw_clear & edge_mode_s;

  // Detection history, sticky flags and the registered event pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      p_r         <= '0;
      pending_r   <= '0;
      overflow_r  <= '0;
      irq_pulse_r <= '0;
    end else begin
      p_r         <= s_s;
      pending_r   <= (pending_r & ~sw_clear) | evt_s | sw_set;
      overflow_r  <= (overflow_r & ~sw_clear) | ovf_set_s;
      irq_pulse_r <= evt_s;
    end
  end

  assign pending   = pending_r;
  assign overflow  = overflow_r;
  assign irq_pulse = irq_pulse_r;
  assign irq_any   = |(pending_r & enable);

endmodule

// File: tb/tb_interrupt_request_capture.sv
// Table-driven bench for interrupt_request_capture (32 channels, 2 sync stages)
// with a scoreboard queue and hand-written reset/overflow sequences.
module tb_interrupt_request_capture;

  logic        clk;
  logic        n_rst;
  logic [31:0] irq_in;
  logic [63:0] mode;
  logic [31:0] enable;
  logic [31:0] sw_set;
  logic [31:0] sw_clear;
  logic [31:0] pending;
  logic [31:0] overflow;
  logic [31:0] irq_pulse;
  logic        irq_any;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] irq;
    logic [31:0] en;
    logic [31:0] set;
    logic [31:0] clr;
    logic [63:0] md;
    logic [31:0] exp_pend;
    logic [31:0] exp_ovf;
    logic [31:0] exp_pulse;
    logic        exp_any;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  interrupt_request_capture #(.N_INTERRUPTS(32), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .irq_in    (irq_in),
    .mode      (mode),
    .enable    (enable),
    .sw_set    (sw_set),
    .sw_clear  (sw_clear),
    .pending   (pending),
    .overflow  (overflow),
    .irq_pulse (irq_pulse),
    .irq_any   (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [31:0] irq, logic [31:0] en, logic [31:0] set,
                              logic [31:0] clr, logic [63:0] md, logic [31:0] pend,
                              logic [31:0] ovf, logic [31:0] pulse, logic any);
    vec_t v;
    v.irq = irq; v.en = en; v.set = set; v.clr = clr; v.md = md;
    v.exp_pend = pend; v.exp_ovf = ovf; v.exp_pulse = pulse; v.exp_any = any;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic [31:0] irq, logic [31:0] en, logic [31:0] set,
                       logic [31:0] clr, logic [63:0] md);
    irq_in = irq; enable = en; sw_set = set; sw_clear = clr; mode = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] EN   = 32'h0000_002F;
  localparam logic [31:0] ENA  = 32'h0000_00AF;
  localparam logic [63:0] M1   = 64'h0000_0000_0000_0C09;
  localparam logic [63:0] M2   = 64'h0000_0000_0000_0C49;
  localparam logic [63:0] MB   = {32{2'b10}};
  localparam logic [31:0] ALL  = 32'hFFFF_FFFF;
  localparam logic [31:0] Z    = 32'h0000_0000;

  initial begin
    vec_t v;
    vec_t e;
    checks   = 0;
    failures = 0;

    // ch0 falling, ch1 both, ch3 rising, ch5 level, ch7 rising but disabled in EN
    vecs.push_back(mk(32'h00, EN,  Z,     Z,     M1, 32'h00, 32'h0, 32'h00, 1'b0)); // 0
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h00, 32'h0, 32'h00, 1'b0)); // 1
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h00, 32'h0, 32'h00, 1'b0));
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h08, 32'h0, 32'h08, 1'b1)); // 3
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h08, 32'h0, 32'h00, 1'b1));
    vecs.push_back(mk(32'h08, EN,  Z,     32'h08, M1, 32'h00, 32'h0, 32'h00, 1'b0)); // 5
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h00, 32'h0, 32'h00, 1'b0));
    vecs.push_back(mk(32'h0B, EN,  Z,     Z,     M1, 32'h00, 32'h0, 32'h00, 1'b0)); // 7
    vecs.push_back(mk(32'h0B, EN,  Z,     Z,     M1, 32'h00, 32'h0, 32'h00, 1'b0));
    vecs.push_back(mk(32'h0B, EN,  Z,     Z,     M1, 32'h02, 32'h0, 32'h02, 1'b1)); // 9
    vecs.push_back(mk(32'h0B, EN,  Z,     Z,     M1, 32'h02, 32'h0, 32'h00, 1'b1));
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h02, 32'h0, 32'h00, 1'b1)); // 11
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h02, 32'h0, 32'h00, 1'b1));
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h03, 32'h2, 32'h03, 1'b1)); // 13
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h03, 32'h2, 32'h00, 1'b1));
    vecs.push_back(mk(32'h08, EN,  Z,     32'h03, M1, 32'h00, 32'h0, 32'h00, 1'b0)); // 15
    vecs.push_back(mk(32'h28, EN,  Z,     Z,     M1, 32'h00, 32'h0, 32'h00, 1'b0));
    vecs.push_back(mk(32'h28, EN,  Z,     Z,     M1, 32'h00, 32'h0, 32'h00, 1'b0)); // 17
    vecs.push_back(mk(32'h28, EN,  Z,     Z,     M1, 32'h20, 32'h0, 32'h20, 1'b1));
    vecs.push_back(mk(32'h28, EN,  Z,     32'h20, M1, 32'h20, 32'h0, 32'h20, 1'b1)); // 19
    vecs.push_back(mk(32'h28, EN,  Z,     Z,     M1, 32'h20, 32'h0, 32'h20, 1'b1));
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h20, 32'h0, 32'h20, 1'b1)); // 21
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h20, 32'h0, 32'h20, 1'b1));
    vecs.push_back(mk(32'h08, EN,  Z,     Z,     M1, 32'h20, 32'h0, 32'h00, 1'b1)); // 23
    vecs.push_back(mk(32'h08, EN,  Z,     32'h20, M1, 32'h00, 32'h0, 32'h00, 1'b0));
    vecs.push_back(mk(32'h88, EN,  Z,     Z,     M1, 32'h00, 32'h0, 32'h00, 1'b0)); // 25
    vecs.push_back(mk(32'h88, EN,  Z,     Z,     M1, 32'h00, 32'h0, 32'h00, 1'b0));
    vecs.push_back(mk(32'h88, EN,  Z,     Z,     M1, 32'h00, 32'h0, 32'h00, 1'b0)); // 27
    vecs.push_back(mk(32'h88, ENA, 32'h80, Z,    M1, 32'h80, 32'h0, 32'h00, 1'b1));
    vecs.push_back(mk(32'h88, EN,  Z,     Z,     M1, 32'h80, 32'h0, 32'h00, 1'b0)); // 29
    vecs.push_back(mk(32'h88, EN,  Z,     32'h80, M1, 32'h00, 32'h0, 32'h00, 1'b0));
    vecs.push_back(mk(32'h88, EN,  32'h04, 32'h04, M1, 32'h04, 32'h0, 32'h00, 1'b1)); // 31
    vecs.push_back(mk(32'h8C, EN,  Z,     Z,     M1, 32'h04, 32'h0, 32'h00, 1'b1));
    vecs.push_back(mk(32'h8C, EN,  Z,     Z,     M1, 32'h04, 32'h0, 32'h00, 1'b1)); // 33
    vecs.push_back(mk(32'h8C, EN,  Z,     32'h04, M1, 32'h04, 32'h0, 32'h04, 1'b1));
    vecs.push_back(mk(32'h8C, EN,  Z,     32'h04, M1, 32'h00, 32'h0, 32'h00, 1'b0)); // 35
    vecs.push_back(mk(32'h8C, EN,  Z,     Z,     M2, 32'h00, 32'h0, 32'h00, 1'b0));
    vecs.push_back(mk(32'h84, EN,  Z,     Z,     M2, 32'h00, 32'h0, 32'h00, 1'b0)); // 37
    vecs.push_back(mk(32'h84, EN,  Z,     Z,     M2, 32'h00, 32'h0, 32'h00, 1'b0));
    vecs.push_back(mk(32'h84, EN,  Z,     Z,     M2, 32'h08, 32'h0, 32'h08, 1'b1)); // 39
    vecs.push_back(mk(32'h84, EN,  Z,     32'h08, M2, 32'h00, 32'h0, 32'h00, 1'b0));

    drive(Z, EN, Z, Z, M1);
    n_rst = 1'b0;
    #12;
    chk("reset_pending",  pending,   Z);
    chk("reset_overflow", overflow,  Z);
    chk("reset_pulse",    irq_pulse, Z);
    chk("reset_any",      {31'd0, irq_any}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int j = 0; j < vecs.size(); j++) begin
      v = vecs[j];
      drive(v.irq, v.en, v.set, v.clr, v.md);
      exp_q.push_back(v);
      tick();
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at row %0d", j);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("row%0d_pending", j),  pending,   e.exp_pend);
        chk($sformatf("row%0d_overflow", j), overflow,  e.exp_ovf);
        chk($sformatf("row%0d_pulse", j),    irq_pulse, e.exp_pulse);
        chk($sformatf("row%0d_any", j),      {31'd0, irq_any}, {31'd0, e.exp_any});
      end
    end

    // Quiesce every line with all channels disabled, then load all pending bits.
    drive(Z, Z, Z, Z, MB);
    for (int k = 0; k < 4; k++) tick();
    drive(Z, ALL, ALL, Z, MB);
    tick();
    chk("all_set_pending", pending, ALL);
    chk("all_set_overflow", overflow, Z);

    // Both-edge events on already pending channels raise every overflow flag.
    drive(ALL, ALL, Z, Z, MB);
    tick();
    tick();
    tick();
    chk("all_ovf_overflow", overflow, ALL);
    chk("all_ovf_pulse", irq_pulse, ALL);
    chk("all_ovf_any", {31'd0, irq_any}, 32'd1);

    // Falling edge enters the synchroniser, then reset hits mid-cycle.
    drive(Z, ALL, Z, Z, MB);
    tick();
    #3;
    n_rst = 1'b0;
    #1;
    chk("async_rst_pending",  pending,   Z);
    chk("async_rst_overflow", overflow,  Z);
    chk("async_rst_pulse",    irq_pulse, Z);
    chk("async_rst_any",      {31'd0, irq_any}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post_rst%0d_pending", k), pending, Z);
      chk($sformatf("post_rst%0d_pulse", k), irq_pulse, Z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_request_capture.md
# interrupt_request_capture

Parametrised interrupt capture front end. It sits between raw peripheral/pad interrupt lines and the interrupt controller's priority logic. Each channel has an optional input synchroniser and selectable edge or level detection. Events are latched into a sticky pending register with software set and clear, per-channel enable gating and overflow flags, plus a one-cycle event pulse for consumers that expect single-cycle requests.

## Interface
- N_INTERRUPTS, 32: number of channels, 1..64.
- SYNC_STAGES, 2: synchroniser flops per channel, 0..3. A value of 0 means the input feeds detection directly.

- clk  input  1  clock.
- n_rst  input  1  reset, asynchronous, active-low.
- irq_in  input  N_INTERRUPTS  raw interrupt lines.
- mode  input  2*N_INTERRUPTS  per-channel detect mode; channel i uses bits [2i+1:2i]. Encoding: 00 rising, 01 falling, 10 both edges, 11 level-high.
- enable  input  N_INTERRUPTS  per-channel event enable.
- sw_set  input  N_INTERRUPTS  one-cycle software set strobes.
- sw_clear  input  N_INTERRUPTS  one-cycle write-1-to-clear strobes. Each strobe clears both pending and overflow for its channel.
- pending  output  N_INTERRUPTS  sticky pending flags.
- overflow  output  N_INTERRUPTS  sticky flag: an event arrived while the channel was already pending.
- irq_pulse  output  N_INTERRUPTS  registered one-cycle event pulse.
- irq_any  output  1  OR of (pending & enable).

## Operation
- Per channel, s = last synchroniser stage (irq_in when SYNC_STAGES=0).
- p = s delayed by one register. p updates every cycle regardless of mode or enable.
- Raw event by mode:
  - rising: s & ~p
  - falling: ~s & p
  - both: s ^ p
  - level: s
- event = raw & enable[i]. Events on disabled channels are dropped, never deferred. Existing pending bits are retained when enable drops.
- Next pending: (pending & ~sw_clear) | event | sw_set. Set wins over a simultaneous clear.
- Level mode: pending cannot be cleared while s=1 and enabled; it re-sets on the same edge.
- Overflow set: event & pending & ~sw_clear, edge modes only. Level mode never sets overflow.
- Next overflow: (overflow & ~sw_clear) | overflow-set term.
- irq_pulse is event registered. For level mode it stays high every cycle s=1 and enabled. sw_set does not pulse.
- irq_any is combinational from the registers (pending & enable).
- A mode change takes effect on the next cycle. It does not reset p, so switching rising->falling with s=1,p=1 gives no spurious event.
- Bit-independent: no cross-channel interaction.

## Timing
- Reset values are 0 for all synchroniser flops, p, pending, overflow, irq_pulse, and therefore irq_any.
- Detection latency: an irq_in transition captured at clock edge k appears on pending and irq_pulse after edge k+SYNC_STAGES.
  - SYNC_STAGES=2: 3 rising edges from the first sampling edge.
  - SYNC_STAGES=0: 1 edge.
- sw_set / sw_clear take effect on the next edge (1-cycle latency).
- The first edge after reset release compares against p=0. A line already high gives a rising or both-edge event once s goes high.
- Reset asserted mid-operation clears everything asynchronously. In-flight synchroniser data is discarded.
- Pulses narrower than one clock may be missed in every mode. This is not an error.

## Test plan
- Rising edge, SYNC_STAGES=2, ch3 enabled, mode=00:
  - irq_in[3] 0->1 held → irq_pulse[3]=1 for exactly one cycle and pending[3]=1, 3 edges after sampling; irq_any=1.
  - sw_clear[3] → pending[3]=0 next cycle, with no re-trigger while the line stays high.
- Falling and both modes, ch0=01, ch1=10:
  - Pulse both lines 1 for 4 cycles then 0.
  - ch0 gives one event at the fall. ch1 gives two irq_pulse cycles, 4 cycles apart; its second event sets overflow[1] because pending[1] is still set.
- Level mode, ch5=11:
  - Hold irq_in[5]=1 and pulse sw_clear[5] → pending[5] stays 1.
  - Drop the line, wait SYNC_STAGES+1 cycles, then sw_clear[5] → pending[5]=0; overflow[5] never set.
- Enable gating:
  - Rising edge on ch7 with enable[7]=0 → pending[7]=0 and irq_pulse[7]=0.
  - With pending[7] preset via sw_set, dropping enable leaves pending[7]=1 and gives irq_any=0.
- Simultaneous set/clear: sw_set[2]=sw_clear[2]=1 on the same cycle → pending[2]=1. Event plus clear on the same cycle → pending[2]=1, overflow[2]=0.
- Reset mid-operation: all 32 channels pending and overflow set, an edge in flight in the synchroniser, assert n_rst asynchronously → all outputs 0 immediately; no event after release while the line is stable low.
